// File: rtl/wb_commit_if.sv
// wb_commit_if: writeback latch controls, decode read ports and OUT-peripheral
// handshake between the pipeline and the commit unit.
interface wb_commit_if;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       RW;
    logic [1:0] SP;
    logic       SW1;
    logic       out_ld;
    logic [7:0] DataOut;
    logic [1:0] rd_a_addr;
    logic [1:0] rd_b_addr;
    logic [7:0] rd_a_data;
    logic [7:0] rd_b_data;
    logic [7:0] sp_value;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       wb_stall;

    modport slave (
        input  ra, rb, RW, SP, SW1, out_ld, DataOut, rd_a_addr, rd_b_addr, out_ready,
        output rd_a_data, rd_b_data, sp_value, out_data, out_valid, wb_stall
    );

    modport master (
        output ra, rb, RW, SP, SW1, out_ld, DataOut, rd_a_addr, rd_b_addr, out_ready,
        input  rd_a_data, rd_b_data, sp_value, out_data, out_valid, wb_stall
    );
endinterface

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: commits writeback ops into a 4x8 register file (R3 = SP) and an
// output FIFO; read ports see this cycle's committed values via bypass.
module wb_commit_unit #(
    parameter int         OUT_DEPTH = 2,
    parameter logic [7:0] SP_RESET  = 8'hFF
) (
    input logic         clk,
    input logic         rst,
    wb_commit_if.slave  wb
);
    localparam int AW = $clog2(OUT_DEPTH);

    logic [7:0]    regs_q [4];
    logic [7:0]    regs_d [4];
    logic [7:0]    mem_q [OUT_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          full, pop, stall, commit, push, wr;
    logic [1:0]    dest;

    always_comb begin
        full   = cnt_q == (AW+1)'(OUT_DEPTH);
        pop    = (cnt_q != '0) && wb.out_ready;
        stall  = wb.out_ld && full && !pop;
        commit = !stall;
        push   = wb.out_ld && commit;
        wr     = wb.RW && commit;
        dest   = wb.SW1 ? wb.rb : wb.ra;
        regs_d = regs_q;
        // SP op first so a same-cycle RW write to R3 overrides it
        if (commit && wb.SP == 2'b01)
            regs_d[3] = regs_q[3] + 8'd1;
        else if (commit && wb.SP == 2'b10)
            regs_d[3] = regs_q[3] - 8'd1;
        if (wr)
            regs_d[dest] = wb.DataOut;
    end

    assign wb.rd_a_data = regs_d[wb.rd_a_addr];
    assign wb.rd_b_data = regs_d[wb.rd_b_addr];
    assign wb.sp_value  = regs_d[3];
    assign wb.out_data  = mem_q[rd_ptr_q];
    assign wb.out_valid = cnt_q != '0;
    assign wb.wb_stall  = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '{8'd0, 8'd0, 8'd0, SP_RESET};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wb.DataOut;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed stimulus; FIFO output checked by a scoreboard monitor.
module tb_wb_commit_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_commit_if bus();
    wb_commit_unit dut (.clk(clk), .rst(rst), .wb(bus));

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic op(input logic [1:0] a, input logic [1:0] b, input logic rw,
                      input logic [1:0] sp, input logic sw1, input logic ld, input logic [7:0] d);
        bus.ra = a; bus.rb = b; bus.RW = rw; bus.SP = sp;
        bus.SW1 = sw1; bus.out_ld = ld; bus.DataOut = d;
    endtask

    task automatic idle();
        op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted head must match the oldest expected push
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_pop: got %h, required no entry", bus.out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    errors++;
                    $display("FAIL fifo_pop: got %h, required %h", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        bus.rd_a_addr = 2'd0;
        bus.rd_b_addr = 2'd3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_r0", bus.rd_a_data, 8'h00);
        chk("rst_r3", bus.rd_b_data, 8'hFF);
        chk("rst_sp", bus.sp_value, 8'hFF);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_stall", bus.wb_stall, 1'b0);
        cyc(); bus.rd_a_addr = 2'd1; bus.rd_b_addr = 2'd2;
        @(negedge clk);
        chk("rst_r1", bus.rd_a_data, 8'h00);
        chk("rst_r2", bus.rd_b_data, 8'h00);
        // register writes with bypass
        cyc(); op(2'd1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h5A);
        @(negedge clk);
        chk("byp_r1", bus.rd_a_data, 8'h5A);
        chk("byp_r2_untouched", bus.rd_b_data, 8'h00);
        cyc(); op(2'd1, 2'd2, 1'b1, 2'b00, 1'b1, 1'b0, 8'hC3);
        @(negedge clk);
        chk("sw1_r1_kept", bus.rd_a_data, 8'h5A);
        chk("sw1_byp_r2", bus.rd_b_data, 8'hC3);
        cyc(); idle();
        @(negedge clk);
        chk("stored_r1", bus.rd_a_data, 8'h5A);
        chk("stored_r2", bus.rd_b_data, 8'hC3);
        // stack pointer
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("sp_inc_wrap", bus.sp_value, 8'h00);
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("sp_dec_wrap", bus.sp_value, 8'hFF);
        cyc(); idle();
        @(negedge clk);
        chk("sp_stored", bus.sp_value, 8'hFF);
        cyc(); op(2'd3, 2'd0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h40);
        @(negedge clk);
        chk("sp_rw_wins", bus.sp_value, 8'h40);
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("sp_reserved", bus.sp_value, 8'h40);
        // fill FIFO, stall third push
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h11); exp_q.push_back(8'h11);
        @(negedge clk);
        chk("push1_stall", bus.wb_stall, 1'b0);
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h22); exp_q.push_back(8'h22);
        @(negedge clk);
        chk("push2_stall", bus.wb_stall, 1'b0);
        chk("head_11", bus.out_data, 8'h11);
        cyc(); op(2'd1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h33); exp_q.push_back(8'h33);
        bus.rd_a_addr = 2'd1;
        @(negedge clk);
        chk("push3_stall", bus.wb_stall, 1'b1);
        chk("stall_no_byp", bus.rd_a_data, 8'h5A);
        cyc();
        @(negedge clk);
        chk("held_stall", bus.wb_stall, 1'b1);
        chk("held_r1", bus.rd_a_data, 8'h5A);
        cyc(); bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_stall", bus.wb_stall, 1'b0);
        chk("release_byp_r1", bus.rd_a_data, 8'h33);
        cyc(); idle();
        @(negedge clk);
        chk("r1_committed", bus.rd_a_data, 8'h33);
        cyc();
        cyc();
        @(negedge clk);
        chk("drained", bus.out_valid, 1'b0);
        // full FIFO with simultaneous push and pop
        bus.out_ready = 1'b0;
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h44); exp_q.push_back(8'h44);
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h55); exp_q.push_back(8'h55);
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h66); exp_q.push_back(8'h66);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_pushpop_stall", bus.wb_stall, 1'b0);
        cyc(); idle(); bus.out_ready = 1'b0;
        @(negedge clk);
        chk("head_adv_valid", bus.out_valid, 1'b1);
        chk("head_adv_55", bus.out_data, 8'h55);
        cyc(); op(2'd2, 2'd0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h77);
        bus.rd_b_addr = 2'd2;
        @(negedge clk);
        chk("still_full_stall", bus.wb_stall, 1'b1);
        chk("stall_sp_no_byp", bus.sp_value, 8'h40);
        chk("stall_r2_no_byp", bus.rd_b_data, 8'hC3);
        // reset during stall discards everything
        cyc(); rst = 1'b1; exp_q.delete();
        cyc(); rst = 1'b0; idle();
        @(negedge clk);
        chk("rst2_valid", bus.out_valid, 1'b0);
        chk("rst2_data", bus.out_data, 8'h00);
        chk("rst2_stall", bus.wb_stall, 1'b0);
        chk("rst2_sp", bus.sp_value, 8'hFF);
        chk("rst2_r2", bus.rd_b_data, 8'h00);
        cyc(); op(2'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h88); exp_q.push_back(8'h88);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("empty_push_no_fall", bus.out_valid, 1'b0);
        cyc(); idle();
        @(negedge clk);
        chk("post_rst_head", bus.out_data, 8'h88);
        cyc();
        @(negedge clk);
        chk("final_valid", bus.out_valid, 1'b0);
        chk("scoreboard_left", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Consumer end of the Ex/M→writeback latch. It takes the latched writeback controls (ra, rb, RW, SP, SW1, out_ld, DataOut) and commits them to architectural state.
- Architectural state: a 4×8-bit register file with R3 as the stack pointer, and a small output-port FIFO toward the external OUT peripheral.
- Provides two combinational read ports, with write bypass, to the decode stage.
- Raises a stall when the output FIFO cannot accept a value.

Parameters:
- OUT_DEPTH, 2, output FIFO depth in entries (power of two, ≥2).
- SP_RESET, 8'hFF, reset value of R3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ra  in  2  writeback register A index.
- rb  in  2  writeback register B index.
- RW  in  1  register write enable.
- SP  in  2  stack op on R3: 00 none, 01 increment, 10 decrement, 11 none (reserved).
- SW1  in  1  destination select: 0 → ra, 1 → rb.
- out_ld  in  1  push DataOut into the output FIFO.
- DataOut  in  8  writeback data.
- rd_a_addr  in  2  decode read port A index.
- rd_b_addr  in  2  decode read port B index.
- rd_a_data  out  8  read port A data.
- rd_b_data  out  8  read port B data.
- sp_value  out  8  current R3 with bypass applied.
- out_data  out  8  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  peripheral accepts head.
- wb_stall  out  1  writeback not committed this cycle; upstream holds its latch.

Behaviour:
- Reset (rst=1 at posedge):
  - R0–R2 = 0, R3 = SP_RESET.
  - FIFO empty: out_valid = 0, out_data = 0.
  - rst overrides every other input that cycle.
  - A pending stalled op is discarded.
- Commit condition: a writeback op commits at posedge when wb_stall = 0.
  - wb_stall = out_ld & fifo_full & ~(out_valid & out_ready). It is combinational.
  - While wb_stall = 1, no register, SP or FIFO-push update occurs. A FIFO pop still occurs if out_ready = 1.
- Register write: when RW = 1, dest = SW1 ? rb : ra, and reg[dest] <= DataOut. Latency 1 cycle.
- SP op: 01 → R3 <= R3 + 1, 10 → R3 <= R3 − 1.
  - Arithmetic is modulo 256: 8'hFF+1 = 8'h00, 8'h00−1 = 8'hFF.
- Conflict: if RW = 1 and dest = 3 in the same cycle as an SP op, the RW write wins and the SP op is dropped.
- Read ports are combinational. Bypass rule:
  - If a commit this cycle will write reg X (RW write, or SP op on R3), a read of X returns the next value, not the stored one.
  - sp_value follows the same bypass rule.
  - When wb_stall = 1, no bypass is applied.
- Output FIFO:
  - Push when out_ld = 1 and the op commits.
  - Pop when out_valid = 1 and out_ready = 1.
  - Order is FIFO; pointers wrap modulo OUT_DEPTH.
  - out_data is registered from the head entry, and is valid only while out_valid = 1.
  - Simultaneous push and pop when full: both happen, count unchanged, no stall.
  - Simultaneous push and pop when empty: push only; out_valid rises next cycle. There is no fall-through.
- out_ld and RW may both be set; both take effect in the same commit.
- Invalid or reserved SP = 11: no-op.

Test Plan:
- Reset then idle → all reads 0 except R3 = 8'hFF; out_valid = 0; wb_stall = 0.
- RW=1, SW1=0, ra=1, DataOut=8'h5A, rd_a_addr=1 in the same cycle → rd_a_data = 8'h5A combinationally; R1 = 8'h5A after the edge. Repeat with SW1=1, rb=2 → R2 written, R1 unchanged.
- SP sequence:
  - SP=01 from reset → R3 = 8'h00 (wrap).
  - SP=10 → 8'hFF.
  - RW=1 to R3 with DataOut=8'h40 plus SP=01 in the same cycle → R3 = 8'h40.
- out_ready=0, three out_ld pushes of 8'h11, 8'h22, 8'h33:
  - First two commit.
  - Third asserts wb_stall, and its paired RW (R1 ← 8'h33) does not commit.
  - Raise out_ready → pop 8'h11; the held push now commits and R1 becomes 8'h33.
  - Drain order is 11, 22, 33.
- FIFO full with out_ready=1 and out_ld=1 → no stall, count stays 2, head advances.
- rst asserted mid-stall with FIFO full → next cycle FIFO empty, wb_stall = 0, R3 = 8'hFF, and the held op is not committed.
